fcvt_int_s: RTL and testbench

FCVT_INT_S -- requirements
Module: fcvt_int_s

---
 rtl/fcvt_int_s.sv | 166 ++++++++++++++++
 tb/tb_fcvt_int_s.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcvt_int_s.sv
// binary32 -> signed/unsigned INT_W-bit integer conversion, 3-stage pipeline with global stall.
// Define FCVT_INT_FFLAGS_EN to build the {NV,DZ,OF,UF,NX} flag path; otherwise fflags is tied to 0.
module fcvt_int_s #(
  parameter int unsigned INT_W       = 32,
  parameter int unsigned RESET_FLUSH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      rs1,
  input  logic             is_unsigned,
  input  logic [2:0]       rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out,
  output logic [4:0]       fflags
);

  localparam int unsigned MW = 24;       // mantissa with hidden bit
  localparam int unsigned FW = 26;       // fraction bits kept during right alignment
  localparam int unsigned EW = MW + FW;
  localparam logic [7:0] EXP_BIG = 8'(127 + INT_W);
  localparam logic [7:0] EXP_INT = 8'd150;   // unbiased 23: mantissa already integral
  localparam logic [7:0] EXP_LOW = 8'd124;   // below this the value is < 0.25
  localparam logic [INT_W-1:0] SMAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] SMIN = {1'b1, {(INT_W-1){1'b0}}};

  logic adv_c, flush_c;

  // RESET_FLUSH=0 is reserved and flushes exactly like 1
  assign flush_c  = reset & ((RESET_FLUSH != 0) | 1'b1);
  assign adv_c    = !out_valid || out_ready;
  assign in_ready = adv_c;

  // S1: unpack and pick alignment direction/amount
  logic [7:0]    exp_c;
  logic [MW-1:0] mant_c;
  logic          nan_c, big_c, left_c;
  logic [5:0]    sh_c;

  always_comb begin
    exp_c  = rs1[30:23];
    mant_c = {(exp_c != 8'd0), rs1[22:0]};
    nan_c  = (exp_c == 8'hFF) && (rs1[22:0] != 23'd0);
    big_c  = exp_c >= EXP_BIG;
    left_c = exp_c >= EXP_INT;
    sh_c   = 6'(FW);
    if (left_c)
      sh_c = 6'(exp_c - EXP_INT);
    else if (exp_c > EXP_LOW)
      sh_c = 6'(EXP_INT - exp_c);
  end

  logic          s1_valid, s1_sign, s1_nan, s1_big, s1_left, s1_uns;
  logic [5:0]    s1_sh;
  logic [MW-1:0] s1_mant;
  logic [2:0]    s1_rm;

  // S2: align to integer plus guard/sticky; oversize exponents never reach the shifter
  logic [EW-1:0]    ext_c;
  logic [INT_W-1:0] mag_c;
  logic             g_c, st_c;

  always_comb begin
    ext_c = {s1_mant, FW'(0)} >> s1_sh;
    mag_c = INT_W'(ext_c[EW-1:FW]);
    g_c   = ext_c[FW-1];
    st_c  = |ext_c[FW-2:0];
    if (s1_left || s1_big) begin
      mag_c = s1_big ? '0 : (INT_W'(s1_mant) << s1_sh);
      g_c   = 1'b0;
      st_c  = 1'b0;
    end
  end

  logic             s2_valid, s2_sign, s2_nan, s2_big, s2_uns, s2_g, s2_st;
  logic [INT_W-1:0] s2_mag;
  logic [2:0]       s2_rm;

  always_ff @(posedge clk) begin
    if (flush_c) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (adv_c) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv_c) begin
      s1_sign <= rs1[31];
      s1_nan  <= nan_c;
      s1_big  <= big_c;
      s1_left <= left_c;
      s1_uns  <= is_unsigned;
      s1_sh   <= sh_c;
      s1_mant <= mant_c;
      s1_rm   <= rm;
      s2_sign <= s1_sign;
      s2_nan  <= s1_nan;
      s2_big  <= s1_big;
      s2_uns  <= s1_uns;
      s2_g    <= g_c;
      s2_st   <= st_c;
      s2_mag  <= mag_c;
      s2_rm   <= s1_rm;
    end
  end

  // S3: round the magnitude, then negate or saturate
  logic             inexact_c, inc_c, sat_hi_c, sat_lo_c, nv_c;
  logic [INT_W:0]   rmag_c;
  logic [INT_W-1:0] norm_c, res_c;

  always_comb begin
    inexact_c = s2_g || s2_st;
    inc_c     = 1'b0;
    case (s2_rm)
      3'd0:    inc_c = s2_g && (s2_st || s2_mag[0]);
      3'd2:    inc_c = s2_sign && inexact_c;
      3'd3:    inc_c = !s2_sign && inexact_c;
      3'd4:    inc_c = s2_g;
      default: inc_c = 1'b0;
    endcase
    rmag_c   = {1'b0, s2_mag} + (INT_W+1)'(inc_c);
    sat_hi_c = s2_nan || (!s2_sign && (s2_big ||
               (s2_uns ? rmag_c[INT_W] : (rmag_c[INT_W] || rmag_c[INT_W-1]))));
    sat_lo_c = !s2_nan && s2_sign && (s2_big ||
               (s2_uns ? (rmag_c != '0)
                       : (rmag_c[INT_W] || (rmag_c[INT_W-1] && (rmag_c[INT_W-2:0] != '0)))));
    nv_c     = sat_hi_c || sat_lo_c;
    norm_c   = s2_sign ? (~rmag_c[INT_W-1:0] + INT_W'(1)) : rmag_c[INT_W-1:0];
    res_c    = norm_c;
    if (nv_c) begin
      if (sat_hi_c)
        res_c = s2_uns ? '1 : SMAX;
      else
        res_c = s2_uns ? '0 : SMIN;
    end
  end

  always_ff @(posedge clk) begin
    if (flush_c) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else if (adv_c) begin
      out_valid <= s2_valid;
      if (s2_valid)
        out <= res_c;
    end
  end

`ifdef FCVT_INT_FFLAGS_EN
  always_ff @(posedge clk) begin
    if (flush_c)
      fflags <= 5'd0;
    else if (adv_c && s2_valid)
      fflags <= {nv_c, 3'b000, inexact_c && !nv_c};
  end
`else
  assign fflags = 5'd0;
`endif

endmodule

// File: tb/tb_fcvt_int_s.sv
// Bench for fcvt_int_s: spec vectors, stall/reset sequences and a randomized stream
// checked against an exact-arithmetic reference model (32- and 64-bit instances in lockstep).
module tb_fcvt_int_s;

  typedef struct {
    logic [31:0] e32; logic [4:0] f32; bit has32;
    logic [63:0] e64; logic [4:0] f64; bit has64;
    bit lat; int acc;
  } exp_t;

  typedef struct {
    int w; logic [31:0] b; bit uns; logic [2:0] rm;
    logic [63:0] o; bit nv; bit nx;
  } vec_t;

  logic clk = 1'b0;
  logic reset, in_valid, is_unsigned, out_ready;
  logic [31:0] rs1;
  logic [2:0]  rm;
  logic in_ready32, ov32, in_ready64, ov64;
  logic [31:0] o32;
  logic [63:0] o64;
  logic [4:0]  f32, f64;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_pop = 0;
  exp_t q[$];

  fcvt_int_s #(.INT_W(32)) d32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32), .rs1(rs1),
    .is_unsigned(is_unsigned), .rm(rm), .out_valid(ov32), .out_ready(out_ready),
    .out(o32), .fflags(f32));

  fcvt_int_s #(.INT_W(64)) d64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64), .rs1(rs1),
    .is_unsigned(is_unsigned), .rm(rm), .out_valid(ov64), .out_ready(out_ready),
    .out(o64), .fflags(f64));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [4:0] fexp(input bit nv, input bit nx);
`ifdef FCVT_INT_FFLAGS_EN
    return {nv, 3'b000, nx};
`else
    return 5'd0;
`endif
  endfunction

  // Exact value mant*2^e, rounded by comparing the dropped remainder against one half
  function automatic void ref_cvt(input int w, input logic [31:0] b, input bit uns,
                                  input logic [2:0] r, output logic [63:0] o,
                                  output bit nv, output bit nx);
    bit s, inexact, up;
    int e, k;
    logic [127:0] m, qv, rem, half;
    logic signed [129:0] v, lo, hi;
    s = b[31]; nv = 0; nx = 0; inexact = 0; up = 0;
    hi = 130'sd1;
    hi = uns ? ((hi <<< w) - 130'sd1) : ((hi <<< (w - 1)) - 130'sd1);
    lo = 130'sd1;
    lo = uns ? 130'sd0 : -(lo <<< (w - 1));
    if (b[30:23] == 8'hFF) begin
      nv = 1;
      v  = (b[22:0] != 23'd0 || !s) ? hi : lo;
      o  = v[63:0];
      return;
    end
    e = (b[30:23] == 8'd0) ? -126 : int'(b[30:23]) - 127;
    m = 128'(b[22:0]);
    if (b[30:23] != 8'd0) m[23] = 1'b1;
    if (e >= 23) begin
      qv = (e > 90) ? (128'd1 << 100) : (m << (e - 23));
    end else begin
      k = 23 - e;
      if (k > 60) k = 60;
      qv = m >> k;
      rem = m - (qv << k);
      half = 128'd1 << (k - 1);
      inexact = (rem != 128'd0);
      case (r)
        3'd0: up = (rem > half) || ((rem == half) && qv[0]);
        3'd2: up = inexact && s;
        3'd3: up = inexact && !s;
        3'd4: up = (rem >= half);
        default: up = 0;
      endcase
      if (up) qv = qv + 128'd1;
    end
    v = 130'(qv);
    if (s) v = -v;
    if (v > hi) begin nv = 1; v = hi; end
    else if (v < lo) begin nv = 1; v = lo; end
    else nx = inexact;
    o = v[63:0];
  endfunction

  function automatic exp_t mk(input logic [31:0] b, input bit uns, input logic [2:0] r,
                              input bit lat);
    exp_t x; logic [63:0] o; bit nv, nx;
    ref_cvt(32, b, uns, r, o, nv, nx);
    x.e32 = o[31:0]; x.f32 = fexp(nv, nx); x.has32 = 1;
    ref_cvt(64, b, uns, r, o, nv, nx);
    x.e64 = o; x.f64 = fexp(nv, nx); x.has64 = 1;
    x.lat = lat; x.acc = 0;
    return x;
  endfunction

  function automatic vec_t tv(input int w, input logic [31:0] b, input bit uns,
                              input logic [2:0] r, input logic [63:0] o, input bit nv, input bit nx);
    vec_t t;
    t.w = w; t.b = b; t.uns = uns; t.rm = r; t.o = o; t.nv = nv; t.nx = nx;
    return t;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0] ex;
    logic [22:0] fr;
    case ($urandom_range(0, 9))
      0: ex = 8'hFF;
      1: ex = 8'h00;
      2: ex = 8'(156 + $urandom_range(0, 3));
      3: ex = 8'(188 + $urandom_range(0, 3));
      default: ex = 8'($urandom_range(100, 192));
    endcase
    fr = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), ex, fr};
  endfunction

  // Present one operand and hold it until the handshake completes
  task automatic send(input logic [31:0] b, input bit uns, input logic [2:0] r, input exp_t x);
    rs1 = b; is_unsigned = uns; rm = r; in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready32 && !reset) begin
        x.acc = cyc;
        q.push_back(x);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (q.size() == 0) break;
    end
    #1;
    check("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  // Output monitor: in-order scoreboard, latency and hold-while-stalled checks
  logic        held_v = 1'b0;
  logic [31:0] held_o;
  logic [4:0]  held_f;
  always @(negedge clk) begin : mon
    exp_t r;
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (ov32 && !out_ready) begin
        if (held_v) begin
          check("hold_out", 64'(o32), 64'(held_o));
          check("hold_fflags", 64'(f32), 64'(held_f));
        end
        held_v = 1'b1; held_o = o32; held_f = f32;
      end else begin
        held_v = 1'b0;
      end
      if (ov32 && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 64'd1, 64'd0);
        end else begin
          r = q.pop_front();
          n_pop++;
          if (r.has32) begin
            check("out32", 64'(o32), 64'(r.e32));
            check("fflags32", 64'(f32), 64'(r.f32));
          end
          if (r.has64) begin
            check("out_valid64", 64'(ov64), 64'd1);
            check("out64", o64, r.e64);
            check("fflags64", 64'(f64), 64'(r.f64));
          end
          if (r.lat) check("latency", 64'(cyc - r.acc), 64'd3);
        end
      end
    end
  end

  initial begin : main
    vec_t tbl[$];
    exp_t x, first;
    logic [31:0] ops[5];
    logic [31:0] b;
    bit uns;
    logic [2:0] r;
    bit done;
    int pop0;

    tbl.push_back(tv(32, 32'h40490FDB, 0, 3'd0, 64'h3, 0, 1));
    tbl.push_back(tv(32, 32'h3FC00000, 0, 3'd0, 64'h2, 0, 1));
    tbl.push_back(tv(32, 32'h40200000, 0, 3'd0, 64'h2, 0, 1));
    tbl.push_back(tv(32, 32'h40200000, 0, 3'd4, 64'h3, 0, 1));
    tbl.push_back(tv(32, 32'hC0200000, 0, 3'd2, 64'hFFFFFFFD, 0, 1));
    tbl.push_back(tv(32, 32'hC0200000, 1, 3'd1, 64'h0, 1, 0));
    tbl.push_back(tv(32, 32'hBE99999A, 1, 3'd1, 64'h0, 0, 1));
    tbl.push_back(tv(32, 32'h4F000000, 0, 3'd0, 64'h7FFFFFFF, 1, 0));
    tbl.push_back(tv(32, 32'hCF000000, 0, 3'd0, 64'h80000000, 0, 0));
    tbl.push_back(tv(32, 32'h4F800000, 1, 3'd0, 64'hFFFFFFFF, 1, 0));
    tbl.push_back(tv(32, 32'h7FC00000, 0, 3'd0, 64'h7FFFFFFF, 1, 0));
    tbl.push_back(tv(32, 32'h00000000, 0, 3'd0, 64'h0, 0, 0));
    tbl.push_back(tv(32, 32'h80000000, 1, 3'd3, 64'h0, 0, 0));
    tbl.push_back(tv(32, 32'h00000001, 0, 3'd3, 64'h1, 0, 1));
    tbl.push_back(tv(32, 32'h80000001, 0, 3'd2, 64'hFFFFFFFF, 0, 1));
    tbl.push_back(tv(32, 32'h80000001, 1, 3'd2, 64'h0, 1, 0));
    tbl.push_back(tv(32, 32'h7F800000, 1, 3'd0, 64'hFFFFFFFF, 1, 0));
    tbl.push_back(tv(32, 32'hFF800000, 0, 3'd0, 64'h80000000, 1, 0));
    tbl.push_back(tv(32, 32'hFF800000, 1, 3'd0, 64'h0, 1, 0));
    tbl.push_back(tv(32, 32'h40490FDB, 0, 3'd5, 64'h3, 0, 1));
    tbl.push_back(tv(32, 32'h3F000000, 0, 3'd0, 64'h0, 0, 1));
    tbl.push_back(tv(32, 32'h3FC00000, 0, 3'd4, 64'h2, 0, 1));
    tbl.push_back(tv(32, 32'hBFC00000, 0, 3'd3, 64'hFFFFFFFF, 0, 1));
    tbl.push_back(tv(32, 32'h4F7FFFFF, 1, 3'd0, 64'hFFFFFF00, 0, 0));
    tbl.push_back(tv(64, 32'h5F000000, 0, 3'd1, 64'h7FFFFFFFFFFFFFFF, 1, 0));
    tbl.push_back(tv(64, 32'h4F800000, 0, 3'd1, 64'h0000000100000000, 0, 0));
    tbl.push_back(tv(64, 32'hDF000000, 0, 3'd1, 64'h8000000000000000, 0, 0));

    reset = 1'b1; in_valid = 1'b0; rs1 = 32'h3F800000; is_unsigned = 1'b0; rm = 3'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready32), 64'd1);
    check("reset_out_valid", 64'(ov32), 64'd0);
    check("reset_out", 64'(o32), 64'd0);
    check("reset_fflags", 64'(f32), 64'd0);
    @(posedge clk); #1;

    // Spec vectors back to back, exact latency expected
    foreach (tbl[i]) begin
      x = '{default: 0};
      x.lat = 1;
      if (tbl[i].w == 32) begin
        x.has32 = 1; x.e32 = tbl[i].o[31:0]; x.f32 = fexp(tbl[i].nv, tbl[i].nx);
      end else begin
        x.has64 = 1; x.e64 = tbl[i].o; x.f64 = fexp(tbl[i].nv, tbl[i].nx);
      end
      send(tbl[i].b, tbl[i].uns, tbl[i].rm, x);
    end
    in_valid = 1'b0;
    drain();

    // Five-operand stream with the consumer stalling from cycle 3
    ops = '{32'h40490FDB, 32'hC0200000, 32'h3FC00000, 32'h4F000000, 32'hBE99999A};
    pop0 = n_pop;
    first = mk(ops[0], 0, 3'd0, 0);
    for (int i = 0; i < 3; i++) send(ops[i], 0, 3'd0, mk(ops[i], 0, 3'd0, 0));
    out_ready = 1'b0;
    @(negedge clk);
    check("stall_in_ready", 64'(in_ready32), 64'd0);
    check("stall_out_valid", 64'(ov32), 64'd1);
    check("stall_first_out", 64'(o32), 64'(first.e32));
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 3; i < 5; i++) send(ops[i], 0, 3'd0, mk(ops[i], 0, 3'd0, 0));
    in_valid = 1'b0;
    drain();
    check("stream_count", 64'(n_pop - pop0), 64'd5);

    // Reset with two operands in flight; an operand offered during reset is ignored
    send(32'h40490FDB, 0, 3'd0, mk(32'h40490FDB, 0, 3'd0, 0));
    send(32'h4F800000, 1, 3'd0, mk(32'h4F800000, 1, 3'd0, 0));
    reset = 1'b1; rs1 = 32'h40200000; in_valid = 1'b1;
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_reset_out_valid", 64'(ov32), 64'd0);
      if (i == 0) begin
        check("post_reset_in_ready", 64'(in_ready32), 64'd1);
        check("post_reset_out", 64'(o32), 64'd0);
        check("post_reset_fflags", 64'(f32), 64'd0);
      end
    end
    @(posedge clk); #1;
    send(32'hC0200000, 0, 3'd2, mk(32'hC0200000, 0, 3'd2, 1));
    in_valid = 1'b0;
    drain();

    // Randomized stream with random back-pressure and input gaps
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end else begin
            b = rnd_op();
            uns = 1'($urandom);
            r = 3'($urandom_range(0, 7));
            send(b, uns, r, mk(b, uns, r, 0));
          end
        end
        in_valid = 1'b0;
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          if (!done) out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
